// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump engine.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        CNT,
        FETCH,
        SEND,
        SUM
    } dump_state_t;

    localparam logic [7:0] DUMP_HDR  = 8'hA5;
    localparam int         RF_ADDR_W = 4;

endpackage

// File: rtl/reg_dump.sv
// Walks the register file read port and streams a framed packet
// (header, count, data, XOR checksum) over a valid/ready byte link.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int num_reg   = 12,
    parameter int reg_width = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [RF_ADDR_W-1:0] rs_addr,
    input  logic [reg_width-1:0] rs_out,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    generate
        if (num_reg < 1 || num_reg > 16) begin : g_bad_num_reg
            $error("reg_dump: num_reg must be in 1..16");
        end
        if (reg_width < 1 || reg_width > 8) begin : g_bad_reg_width
            $error("reg_dump: reg_width must be in 1..8");
        end
    endgenerate

    localparam logic [RF_ADDR_W-1:0] LAST_IDX = RF_ADDR_W'(num_reg - 1);
    localparam logic [7:0]           NUM_BYTE = 8'(num_reg);

    dump_state_t          state_reg;
    logic [RF_ADDR_W-1:0] idx_reg;
    logic [7:0]           csum_reg;
    logic [7:0]           tx_data_reg;
    logic                 done_reg;
    logic [7:0]           rs_ext;
    logic                 handshake;

    // Zero-extend the register value onto the byte lane.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ext
            if (gi < reg_width) begin : g_bit
                assign rs_ext[gi] = rs_out[gi];
            end else begin : g_zero
                assign rs_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign tx_valid  = (state_reg == HDR) || (state_reg == CNT) ||
                       (state_reg == SEND) || (state_reg == SUM);
    assign handshake = tx_valid && tx_ready;
    assign busy      = (state_reg != IDLE);
    assign rs_addr   = idx_reg;
    assign tx_data   = tx_data_reg;
    assign done      = done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            csum_reg    <= '0;
            tx_data_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // Abort truncates the packet; index returns to 0 so rs_addr idles at 0.
            if (abort && state_reg != IDLE) begin
                state_reg   <= IDLE;
                idx_reg     <= '0;
                csum_reg    <= '0;
                tx_data_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            state_reg   <= HDR;
                            idx_reg     <= '0;
                            csum_reg    <= '0;
                            tx_data_reg <= DUMP_HDR;
                        end
                    end
                    HDR: begin
                        if (handshake) begin
                            state_reg   <= CNT;
                            tx_data_reg <= NUM_BYTE;
                        end
                    end
                    CNT: begin
                        if (handshake) begin
                            state_reg <= FETCH;
                        end
                    end
                    FETCH: begin
                        // Latching here keeps the byte stable under backpressure
                        // even if the datapath rewrites this register.
                        tx_data_reg <= rs_ext;
                        csum_reg    <= csum_reg ^ rs_ext;
                        state_reg   <= SEND;
                    end
                    SEND: begin
                        if (handshake) begin
                            if (idx_reg == LAST_IDX) begin
                                state_reg   <= SUM;
                                tx_data_reg <= csum_reg;
                            end else begin
                                idx_reg   <= idx_reg + 1'b1;
                                state_reg <= FETCH;
                            end
                        end
                    end
                    SUM: begin
                        if (handshake) begin
                            state_reg   <= IDLE;
                            idx_reg     <= '0;
                            csum_reg    <= '0;
                            tx_data_reg <= '0;
                            done_reg    <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: table vectors, corner sequences and
// randomized dumps compared against a packet-level reference model.
module tb_reg_dump;
    import reg_dump_pkg::*;

    localparam int NR = 12;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, abort, tx_ready;
    logic [3:0] rs_addr;
    logic [7:0] rs_out, tx_data;
    logic       tx_valid, busy, done;
    logic [7:0] rf [16];
    assign rs_out = rf[rs_addr];

    logic       start4;
    logic [3:0] rs_addr4, rs_out4;
    logic [7:0] tx_data4;
    logic       tx_valid4, busy4, done4;
    logic [3:0] rf4 [16];
    assign rs_out4 = rf4[rs_addr4];

    reg_dump #(.num_reg(NR), .reg_width(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rs_addr(rs_addr), .rs_out(rs_out), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    reg_dump #(.num_reg(3), .reg_width(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .abort(1'b0),
        .rs_addr(rs_addr4), .rs_out(rs_out4), .tx_data(tx_data4),
        .tx_valid(tx_valid4), .tx_ready(1'b1), .busy(busy4), .done(done4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sink-side monitor: captured bytes, busy/done counts, hold-under-stall rule.
    logic [7:0] got[$];
    logic [7:0] got4[$];
    int         busy_cnt  = 0;
    int         done_cnt  = 0;
    int         done4_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (tx_valid4) got4.push_back(tx_data4);
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done4) done4_cnt <= done4_cnt + 1;
        if (prev_stall) begin
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        prev_stall <= tx_valid && !tx_ready && !reset && !abort;
        prev_data  <= tx_data;
    end

    // Reference model: packet = A5, count, registers, XOR of registers.
    logic [7:0] exp_pkt[$];
    task automatic make_model();
        logic [7:0] x;
        x = 8'h00;
        exp_pkt.delete();
        exp_pkt.push_back(8'hA5);
        exp_pkt.push_back(8'(NR));
        for (int i = 0; i < NR; i++) begin
            exp_pkt.push_back(rf[i]);
            x = x ^ rf[i];
        end
        exp_pkt.push_back(x);
    endtask

    task automatic compare_packet(input string name);
        check({name, "_len"}, got.size(), exp_pkt.size());
        for (int i = 0; i < exp_pkt.size(); i++) begin
            if (i < got.size())
                check($sformatf("%s_b%0d", name, i), {24'd0, got[i]}, {24'd0, exp_pkt[i]});
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, {31'd0, tx_valid}, 32'd0);
        check({name, "_data"}, {24'd0, tx_data}, 32'd0);
        check({name, "_addr"}, {28'd0, rs_addr}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic do_start();
        got.delete();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Drives tx_ready per mode until done; done_k is cycles after the start edge.
    task automatic collect(input int mode, output int done_k);
        bit trig;
        int stall;
        trig   = 1'b0;
        stall  = 0;
        done_k = -1;
        for (int k = 1; k <= 400; k++) begin
            case (mode)
                1: tx_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!trig && tx_valid && rs_addr == 4'd3) begin
                        trig  = 1'b1;
                        stall = 5;
                    end
                    if (stall > 0) begin
                        tx_ready = 1'b0;
                        if (stall == 3) rf[3] = 8'hEE;
                        stall--;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
                3: begin
                    tx_ready = 1'b1;
                    start    = (k == 5 || k == 10);
                end
                4: begin
                    tx_ready = 1'b1;
                    start    = done;
                end
                default: tx_ready = 1'b1;
            endcase
            @(negedge clk); #1;
            if (done) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_k < 0) check("timeout_waiting_done", 32'd0, 32'd1);
    endtask

    task automatic load_count();
        for (int i = 0; i < 16; i++) rf[i] = 8'(i + 1);
    endtask

    typedef struct {
        string      name;
        logic [95:0] regs;
        logic [7:0] exp_sum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, b0, d0;
        bit found;

        vecs[0] = '{"count",  96'h0C0B0A09_08070605_04030201, 8'h0C};
        vecs[1] = '{"all_ff", {12{8'hFF}},                    8'h00};
        vecs[2] = '{"r7_80",  96'h00000000_80000000_00000000, 8'h80};
        vecs[3] = '{"zeros",  96'h0,                          8'h00};
        vecs[4] = '{"ends",   96'h34000000_00000000_00000012, 8'h26};

        reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0; start4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rf[i]  = 8'h00;
            rf4[i] = 4'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Table-driven dumps with tx_ready held high.
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NR; i++) rf[i] = vecs[v].regs[8*i +: 8];
            make_model();
            b0 = busy_cnt;
            do_start();
            collect(0, k);
            check({vecs[v].name, "_done_cycle"}, k, 28);
            check({vecs[v].name, "_busy_cycles"}, busy_cnt - b0, 27);
            compare_packet(vecs[v].name);
            if (got.size() > 14)
                check({vecs[v].name, "_csum"}, {24'd0, got[14]}, {24'd0, vecs[v].exp_sum});
        end

        // Backpressure on r3 while the datapath rewrites it.
        load_count();
        make_model();
        do_start();
        collect(2, k);
        compare_packet("backpressure");

        // start pulses while busy are ignored.
        load_count();
        make_model();
        d0 = done_cnt;
        do_start();
        collect(3, k);
        check("busy_start_done_cycle", k, 28);
        repeat (4) @(posedge clk);
        #1;
        check("busy_start_one_packet", got.size(), 15);
        check("busy_start_one_done", done_cnt - d0, 1);

        // start coincident with done begins a new packet next cycle.
        do_start();
        collect(4, k);
        compare_packet("sod_first");
        @(posedge clk); #1 start = 1'b0;
        got.delete();
        check("sod_valid", {31'd0, tx_valid}, 32'd1);
        check("sod_hdr", {24'd0, tx_data}, 32'hA5);
        check("sod_busy", {31'd0, busy}, 32'd1);
        collect(0, k);
        check("sod_second_done_cycle", k, 28);
        compare_packet("sod_second");

        // Abort during SEND of r5, simultaneous with a handshake.
        d0 = done_cnt;
        found = 1'b0;
        do_start();
        for (int c = 0; c < 60; c++) begin
            tx_ready = 1'b1;
            if (tx_valid && rs_addr == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("abort_reached_r5", {31'd0, found}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_addr", {28'd0, rs_addr}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_truncated_len", got.size(), 8);
        make_model();
        do_start();
        collect(0, k);
        compare_packet("after_abort");

        // Reset while the count byte is on the link.
        do_start();
        tx_ready = 1'b1;
        @(posedge clk); #1;
        check("cnt_byte", {24'd0, tx_data}, NR);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check_idle_outputs("reset_mid");
        @(posedge clk); #1;

        // Randomized registers and randomized sink readiness.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
            make_model();
            d0 = done_cnt;
            do_start();
            collect(1, k);
            compare_packet($sformatf("rand%0d", r));
            #10;
            check($sformatf("rand%0d_done_once", r), done_cnt - d0, 1);
        end

        // 4-bit registers are zero-extended on the stream.
        rf4[0] = 4'hF; rf4[1] = 4'h3; rf4[2] = 4'h9;
        got4.delete();
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        begin
            logic [7:0] exp4 [6];
            exp4 = '{8'hA5, 8'h03, 8'h0F, 8'h03, 8'h09, 8'h05};
            check("w4_len", got4.size(), 6);
            for (int i = 0; i < 6; i++)
                if (i < got4.size())
                    check($sformatf("w4_b%0d", i), {24'd0, got4[i]}, {24'd0, exp4[i]});
        end
        check("w4_done_once", done4_cnt, 1);
        check("w4_idle", {31'd0, busy4}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
